hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage MIPS core. It sits beside the IF/ID register.
//  It detects load-use and jr-source hazards and sequences jump, jr and beq/bne control transfers.
//  Its outputs drive the PC write-enable, the IF/ID write-enable, the ID/EX bubble insertion and the next-PC mux.
//  Beyond single-cycle operation it supports multi-cycle load latency, multi-cycle branch resolution, bne and a jr redirect.
// PARAMETERS
//  REG_AW          5   register-address width
//  LD_STALL_CYC    1   bubble cycles inserted per load-use hazard (>=1)
//  BR_RESOLVE_CYC  1   cycles from branch decode until ALUZero is valid (>=1)
//  CNT_W           16  performance-counter width
// PORTS
//  Clk            in   1       clock; state updates on negedge Clk
//  Rst            in   1       asynchronous reset, active-low
//  Jump           in   1       j/jal in ID
//  Jr             in   1       jr in ID
//  Branch         in   1       beq/bne in ID
//  BranchNe       in   1       1 = bne, 0 = beq; sampled with Branch and held by the core until resolution
//  ALUZero        in   1       branch compare result from EX
//  memReadEX      in   1       instruction in EX is a load
//  UseShamt       in   1       ID instruction uses shamt, not rt
//  UseImmed       in   1       ID instruction uses immediate, not rt
//  currRs,currRt  in   REG_AW  ID source registers
//  prevRt         in   REG_AW  load destination in EX
//  EX_RegWrite    in   1       EX-stage write enable
//  MEM_RegWrite   in   1       MEM-stage write enable
//  EX_Rw,MEM_Rw   in   REG_AW  EX- and MEM-stage destinations
//  IF_write       out  1       IF/ID register write enable
//  PC_write       out  1       PC write enable
//  bubble         out  1       zero the ID/EX control signals
//  addrSel        out  2       next-PC select: 00 PC+4, 01 jump, 10 branch, 11 jr (rs)
//  stall_cnt      out  CNT_W   cycles with PC_write=0 (perf)
//  flush_cnt      out  CNT_W   taken control transfers (perf)
// BEHAVIOUR
//  Detection (combinational):
//   LdHaz = memReadEX & prevRt!=0 & (currRs==prevRt | (!UseShamt & !UseImmed & currRt==prevRt)) & !(UseShamt & UseImmed)
//   JrHaz = Jr & currRs!=0 & ((EX_RegWrite & EX_Rw==currRs) | (MEM_RegWrite & MEM_Rw==currRs))
//  Output tuple is {IF_write,PC_write,bubble,addrSel}. States: RUN, LD_STALL, XFER_FLUSH, BR_WAIT.
//  Counter cnt has width clog2(max delay)+1.
//  RUN, priority order:
//   LdHaz          -> 0,0,1,00; if LD_STALL_CYC>1 go LD_STALL with cnt=LD_STALL_CYC-2, else stay RUN
//   JrHaz          -> 0,0,1,00; stay RUN; re-evaluated every cycle
//   Jump           -> 0,1,0,01; go XFER_FLUSH
//   Jr             -> 0,1,0,11; go XFER_FLUSH
//   Branch         -> 0,0,0,00; go BR_WAIT with cnt=BR_RESOLVE_CYC-1
//   none           -> 1,1,0,00
//  LD_STALL:
//   output 0,0,1,00
//   cnt==0 -> RUN, else decrement
//  XFER_FLUSH:
//   output 1,1,1,00
//   -> RUN
//  BR_WAIT:
//   cnt!=0 -> 0,0,1,00 and decrement
//   cnt==0 -> taken = ALUZero ^ BranchNe
//    taken     -> 0,1,1,10 and go XFER_FLUSH
//    not taken -> 1,1,1,00 and go RUN
//  Hazard and Jump/Branch inputs are ignored outside RUN. A simultaneous load hazard and jump stalls first.
//   The jump is taken once the hazard clears.
//  Reset: Rst low clears the state to RUN and cnt to 0 immediately.
//   While Rst is low, outputs are forced to 0,0,1,00 and the perf counters to 0.
//   Reset asserted mid-branch or mid-stall abandons the sequence.
//  Unused state encoding -> RUN with outputs 1,1,0,00.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   stall_cnt increments on every negedge with PC_write==0 and Rst high.
//   flush_cnt increments on every Jump, Jr or taken-branch redirect.
//   Both counters saturate at all-ones.
//  HAZARD_PERF_CNT_EN undefined: the ports remain and are tied to 0; no counter flops are built.
// STRUCTURE
//  Package hazard_pkg holds the state encodings and the addrSel constants (ADDR_PC4, ADDR_JMP, ADDR_BR, ADDR_JR).
//  Sub-module hazard_detect holds the combinational LdHaz/JrHaz logic and is parametrised by REG_AW.
//  The FSM, counter and perf counters live in the top module.
// TESTING
//  1. lw $5 in EX, ID add rs=$5, LD_STALL_CYC=2 -> 0,0,1 for exactly 2 cycles, then 1,1,0,00.
//  2. lw $0 in EX, ID rs=$0 -> no stall.
//     UseImmed=1 with rt=prevRt=$7, rs!=$7 -> no stall.
//  3. beq with ALUZero=1, BR_RESOLVE_CYC=2 -> 0,0,0 | 0,0,1 | 0,1,1,10 | 1,1,1,00.
//     bne with ALUZero=1 -> not taken: 1,1,1,00.
//  4. Jr with EX_Rw=currRs=$31 and EX_RegWrite=1 -> stall.
//     Next cycle hazard cleared -> 0,1,0,11, then flush.
//  5. Rst pulled low during BR_WAIT -> outputs 0,0,1,00 asynchronously; RUN after release.
//  6. HAZARD_PERF_CNT_EN: tests 1+3 -> stall_cnt=5, flush_cnt=1; saturation at CNT_W=2.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller.
//  - FSM state encodings
//  - next-PC select constants (ADDR_PC4/ADDR_JMP/ADDR_BR/ADDR_JR)
//  - control-output tuple struct and the fixed tuples the FSM emits
//  - helper for sizing the delay counter
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LD_STALL   = 2'd1,
    ST_XFER_FLUSH = 2'd2,
    ST_BR_WAIT    = 2'd3
  } hz_state_e;

  localparam logic [1:0] ADDR_PC4 = 2'b00;
  localparam logic [1:0] ADDR_JMP = 2'b01;
  localparam logic [1:0] ADDR_BR  = 2'b10;
  localparam logic [1:0] ADDR_JR  = 2'b11;

  typedef struct packed {
    logic       if_write;
    logic       pc_write;
    logic       bubble;
    logic [1:0] addr_sel;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_RUN   = '{1'b1, 1'b1, 1'b0, ADDR_PC4};
  localparam hz_ctl_t CTL_STALL = '{1'b0, 1'b0, 1'b1, ADDR_PC4};
  localparam hz_ctl_t CTL_FLUSH = '{1'b1, 1'b1, 1'b1, ADDR_PC4};

  function automatic int hz_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection for the ID stage.
//  ld_haz_o : ID instruction reads the destination of the load currently in EX
//  jr_haz_o : jr source register is still being produced in EX or MEM
// Ports: ID operand info (rs/rt, shamt/immediate usage, jr), EX load info
// (mem_read_ex_i, prev_rt_i), EX/MEM writeback info (reg_write + dest).
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              mem_read_ex_i,
  input  logic              use_shamt_i,
  input  logic              use_immed_i,
  input  logic              jr_i,
  input  logic              ex_reg_write_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] curr_rs_i,
  input  logic [REG_AW-1:0] curr_rt_i,
  input  logic [REG_AW-1:0] prev_rt_i,
  input  logic [REG_AW-1:0] ex_rw_i,
  input  logic [REG_AW-1:0] mem_rw_i,
  output logic              ld_haz_o,
  output logic              jr_haz_o
);

  logic rt_used;

  // rt is only a source when neither shamt nor immediate replaces it
  assign rt_used = !use_shamt_i && !use_immed_i;

  // shamt+immed together marks an instruction with no register sources
  assign ld_haz_o = mem_read_ex_i && (prev_rt_i != '0) &&
                    ((curr_rs_i == prev_rt_i) || (rt_used && (curr_rt_i == prev_rt_i))) &&
                    !(use_shamt_i && use_immed_i);

  assign jr_haz_o = jr_i && (curr_rs_i != '0) &&
                    ((ex_reg_write_i && (ex_rw_i == curr_rs_i)) ||
                     (mem_reg_write_i && (mem_rw_i == curr_rs_i)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core (beside IF/ID).
// Stalls on load-use and jr-source hazards, sequences j/jal, jr and beq/bne.
// State updates on negedge Clk; Rst is asynchronous active-low.
// Inputs : Jump, Jr, Branch, BranchNe, ALUZero, memReadEX, UseShamt, UseImmed,
//          currRs, currRt, prevRt, EX_RegWrite, MEM_RegWrite, EX_Rw, MEM_Rw
// Outputs: IF_write, PC_write, bubble, addrSel (next-PC select),
//          stall_cnt / flush_cnt performance counters
// Optional feature macro: HAZARD_PERF_CNT_EN builds the saturating perf
// counters; without it both counter ports are tied to 0.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int LD_STALL_CYC   = 1,
  parameter int BR_RESOLVE_CYC = 1,
  parameter int CNT_W          = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Jump,
  input  logic              Jr,
  input  logic              Branch,
  input  logic              BranchNe,
  input  logic              ALUZero,
  input  logic              memReadEX,
  input  logic              UseShamt,
  input  logic              UseImmed,
  input  logic [REG_AW-1:0] currRs,
  input  logic [REG_AW-1:0] currRt,
  input  logic [REG_AW-1:0] prevRt,
  input  logic              EX_RegWrite,
  input  logic              MEM_RegWrite,
  input  logic [REG_AW-1:0] EX_Rw,
  input  logic [REG_AW-1:0] MEM_Rw,
  output logic              IF_write,
  output logic              PC_write,
  output logic              bubble,
  output logic [1:0]        addrSel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MAX_DLY = hz_max(LD_STALL_CYC, BR_RESOLVE_CYC);
  localparam int CW      = $clog2(MAX_DLY) + 1;

  hz_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  hz_ctl_t         ctl, ctl_out;
  logic            ld_haz, jr_haz, taken;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .mem_read_ex_i   (memReadEX),
    .use_shamt_i     (UseShamt),
    .use_immed_i     (UseImmed),
    .jr_i            (Jr),
    .ex_reg_write_i  (EX_RegWrite),
    .mem_reg_write_i (MEM_RegWrite),
    .curr_rs_i       (currRs),
    .curr_rt_i       (currRt),
    .prev_rt_i       (prevRt),
    .ex_rw_i         (EX_Rw),
    .mem_rw_i        (MEM_Rw),
    .ld_haz_o        (ld_haz),
    .jr_haz_o        (jr_haz)
  );

  assign taken = ALUZero ^ BranchNe;

  // state register
  always_ff @(negedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ld_haz) begin
          // the RUN cycle itself is the first bubble
          if (LD_STALL_CYC > 1) begin
            state_d = ST_LD_STALL;
            cnt_d   = CW'(LD_STALL_CYC - 2);
          end
        end else if (jr_haz) begin
          state_d = ST_RUN;
        end else if (Jump || Jr) begin
          state_d = ST_XFER_FLUSH;
        end else if (Branch) begin
          state_d = ST_BR_WAIT;
          cnt_d   = CW'(BR_RESOLVE_CYC - 1);
        end
      end
      ST_LD_STALL: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_XFER_FLUSH: state_d = ST_RUN;
      ST_BR_WAIT: begin
        if (cnt_q != '0)  cnt_d   = cnt_q - CW'(1);
        else if (taken)   state_d = ST_XFER_FLUSH;
        else              state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // output logic
  always_comb begin
    ctl = CTL_RUN;
    case (state_q)
      ST_RUN: begin
        if (ld_haz || jr_haz) ctl = CTL_STALL;
        else if (Jump)        ctl = '{1'b0, 1'b1, 1'b0, ADDR_JMP};
        else if (Jr)          ctl = '{1'b0, 1'b1, 1'b0, ADDR_JR};
        else if (Branch)      ctl = '{1'b0, 1'b0, 1'b0, ADDR_PC4};
        else                  ctl = CTL_RUN;
      end
      ST_LD_STALL:   ctl = CTL_STALL;
      ST_XFER_FLUSH: ctl = CTL_FLUSH;
      ST_BR_WAIT: begin
        if (cnt_q != '0) ctl = CTL_STALL;
        else if (taken)  ctl = '{1'b0, 1'b1, 1'b1, ADDR_BR};
        else             ctl = CTL_FLUSH;
      end
      default: ctl = CTL_RUN;
    endcase
  end

  // reset overrides the outputs without waiting for a clock edge
  assign ctl_out  = Rst ? ctl : CTL_STALL;
  assign IF_write = ctl_out.if_write;
  assign PC_write = ctl_out.pc_write;
  assign bubble   = ctl_out.bubble;
  assign addrSel  = ctl_out.addr_sel;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             redirect;

  // every PC redirect (jump, jr, taken branch) writes the PC with a non-PC+4 select
  assign redirect = ctl.pc_write && (ctl.addr_sel != ADDR_PC4);

  always_ff @(negedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ctl.pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect && (flush_cnt_q != '1))      flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
